// File: rtl/csrsr_nested.sv
// Machine/supervisor status register with a LIFO of saved machine trap contexts.
// Nested M-mode traps push {MPIE,MPP}; mret pops it back, so nesting is restored exactly.
module csrsr_nested #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 4,
  parameter int S_SUPPORTED  = 1,
  parameter int U_SUPPORTED  = 1,
  parameter int FP_SUPPORTED = 1,
  localparam int DW          = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallW,
  input  logic            TrapM,
  input  logic [1:0]      NextPrivilegeModeM,
  input  logic [1:0]      PrivilegeModeW,
  input  logic            mretM,
  input  logic            sretM,
  input  logic            WriteMSTATUSM,
  input  logic            WriteSSTATUSM,
  input  logic [XLEN-1:0] CSRWriteValM,
  input  logic            FRegWriteM,
  input  logic            WriteFRMM,
  input  logic            WriteFFLAGSM,
  input  logic            ClearOvfM,
  output logic [XLEN-1:0] MSTATUS_REGW,
  output logic [XLEN-1:0] SSTATUS_REGW,
  output logic            STATUS_MIE,
  output logic            STATUS_SIE,
  output logic            STATUS_MPIE,
  output logic            STATUS_SPIE,
  output logic            STATUS_SPP,
  output logic [1:0]      STATUS_MPP,
  output logic [1:0]      STATUS_FS,
  output logic [DW-1:0]   NestDepth,
  output logic            NestOvf,
  output logic            NestUnf
);

  localparam bit HAS_S  = (S_SUPPORTED != 0);
  localparam bit HAS_U  = (U_SUPPORTED != 0);
  localparam bit HAS_FP = (FP_SUPPORTED != 0);
  localparam logic [1:0]    LOWEST_MODE = HAS_U ? 2'b00 : 2'b11;
  localparam logic [DW-1:0] FULL        = DW'(DEPTH);

  logic          mie_reg,  mie_next;
  logic          sie_reg,  sie_next;
  logic          mpie_reg, mpie_next;
  logic          spie_reg, spie_next;
  logic          spp_reg,  spp_next;
  logic [1:0]    mpp_reg,  mpp_next;
  logic [1:0]    fs_reg,   fs_next;
  logic [DW-1:0] depth_reg, depth_next;
  logic          ovf_reg,  ovf_next;
  logic          unf_reg,  unf_next;
  logic          push, pop, ovf_set;

  logic [2:0] stack_reg  [DEPTH];
  logic [2:0] stack_next [DEPTH];

  // Unencodable or unsupported previous-privilege values collapse to M.
  function automatic logic [1:0] legal_mpp(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      2'b11:   r = 2'b11;
      2'b01:   r = HAS_S ? 2'b01 : 2'b11;
      2'b00:   r = HAS_U ? 2'b00 : 2'b11;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  always_comb begin
    mie_next   = mie_reg;
    sie_next   = sie_reg;
    mpie_next  = mpie_reg;
    spie_next  = spie_reg;
    spp_next   = spp_reg;
    mpp_next   = mpp_reg;
    fs_next    = fs_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;

    if (!StallW) begin
      if (TrapM) begin
        if (NextPrivilegeModeM == 2'b11) begin
          push      = 1'b1;
          mpie_next = mie_reg;
          mie_next  = 1'b0;
          mpp_next  = PrivilegeModeW;
          if (depth_reg == FULL) ovf_set = 1'b1;
          else                   depth_next = depth_reg + 1'b1;
        end else if (NextPrivilegeModeM == 2'b01 && HAS_S) begin
          spie_next = sie_reg;
          sie_next  = 1'b0;
          spp_next  = PrivilegeModeW[0];
        end
      end else if (mretM) begin
        mie_next = mpie_reg;
        if (depth_reg != '0) begin
          pop                   = 1'b1;
          {mpie_next, mpp_next} = stack_reg[0];
          depth_next            = depth_reg - 1'b1;
        end else begin
          mpie_next = 1'b1;
          mpp_next  = LOWEST_MODE;
          unf_next  = 1'b1;
        end
      end else if (sretM) begin
        if (HAS_S) begin
          sie_next  = spie_reg;
          spie_next = 1'b1;
          spp_next  = 1'b0;
        end
      end else if (WriteMSTATUSM) begin
        mie_next  = CSRWriteValM[3];
        mpie_next = CSRWriteValM[7];
        mpp_next  = legal_mpp(CSRWriteValM[12:11]);
        if (HAS_S) begin
          sie_next  = CSRWriteValM[1];
          spie_next = CSRWriteValM[5];
          spp_next  = CSRWriteValM[8];
        end
        if (HAS_FP) fs_next = CSRWriteValM[14:13];
      end else if (WriteSSTATUSM) begin
        if (HAS_S) begin
          sie_next  = CSRWriteValM[1];
          spie_next = CSRWriteValM[5];
          spp_next  = CSRWriteValM[8];
        end
        if (HAS_FP) fs_next = CSRWriteValM[14:13];
      end else if ((FRegWriteM || WriteFRMM || WriteFFLAGSM) && HAS_FP) begin
        fs_next = 2'b11;
      end

      // A same-cycle overflowing push beats the clear.
      if (ovf_set)        ovf_next = 1'b1;
      else if (ClearOvfM) ovf_next = 1'b0;
    end
  end

  // Push shifts every entry one slot older (the oldest falls off); pop shifts newer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stack
      logic [2:0] from_newer;
      logic [2:0] from_older;
      if (gi == 0) begin : g_top
        assign from_newer = {mpie_reg, mpp_reg};
      end else begin : g_mid
        assign from_newer = stack_reg[gi-1];
      end
      if (gi == DEPTH - 1) begin : g_bot
        assign from_older = 3'b000;
      end else begin : g_rest
        assign from_older = stack_reg[gi+1];
      end
      always_comb begin
        stack_next[gi] = stack_reg[gi];
        if (push)     stack_next[gi] = from_newer;
        else if (pop) stack_next[gi] = from_older;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_reg   <= 1'b0;
      sie_reg   <= 1'b0;
      mpie_reg  <= 1'b0;
      spie_reg  <= 1'b0;
      spp_reg   <= 1'b0;
      mpp_reg   <= 2'b00;
      fs_reg    <= 2'b00;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= 3'b000;
    end else begin
      mie_reg   <= mie_next;
      sie_reg   <= sie_next;
      mpie_reg  <= mpie_next;
      spie_reg  <= spie_next;
      spp_reg   <= spp_next;
      mpp_reg   <= mpp_next;
      fs_reg    <= fs_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= stack_next[i];
    end
  end

  logic sd;
  assign sd = (fs_reg == 2'b11);

  always_comb begin
    MSTATUS_REGW         = '0;
    MSTATUS_REGW[XLEN-1] = sd;
    MSTATUS_REGW[14:13]  = fs_reg;
    MSTATUS_REGW[12:11]  = mpp_reg;
    MSTATUS_REGW[8]      = spp_reg;
    MSTATUS_REGW[7]      = mpie_reg;
    MSTATUS_REGW[5]      = spie_reg;
    MSTATUS_REGW[3]      = mie_reg;
    MSTATUS_REGW[1]      = sie_reg;
  end

  always_comb begin
    SSTATUS_REGW         = '0;
    SSTATUS_REGW[XLEN-1] = sd;
    SSTATUS_REGW[14:13]  = fs_reg;
    SSTATUS_REGW[8]      = spp_reg;
    SSTATUS_REGW[5]      = spie_reg;
    SSTATUS_REGW[1]      = sie_reg;
  end

  assign STATUS_MIE  = mie_reg;
  assign STATUS_SIE  = sie_reg;
  assign STATUS_MPIE = mpie_reg;
  assign STATUS_SPIE = spie_reg;
  assign STATUS_SPP  = spp_reg;
  assign STATUS_MPP  = mpp_reg;
  assign STATUS_FS   = fs_reg;
  assign NestDepth   = depth_reg;
  assign NestOvf     = ovf_reg;
  assign NestUnf     = unf_reg;

endmodule

// File: tb/tb_csrsr_nested.sv
// Directed bench for csrsr_nested with a two-entry context stack.
module tb_csrsr_nested;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int DW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset_n;
  logic            StallW, TrapM, mretM, sretM;
  logic [1:0]      NextPrivilegeModeM, PrivilegeModeW;
  logic            WriteMSTATUSM, WriteSSTATUSM;
  logic [XLEN-1:0] CSRWriteValM;
  logic            FRegWriteM, WriteFRMM, WriteFFLAGSM, ClearOvfM;
  logic [XLEN-1:0] MSTATUS_REGW, SSTATUS_REGW;
  logic            STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP;
  logic [1:0]      STATUS_MPP, STATUS_FS;
  logic [DW-1:0]   NestDepth;
  logic            NestOvf, NestUnf;

  int total = 0;
  int bad   = 0;

  csrsr_nested #(.XLEN(XLEN), .DEPTH(DEPTH), .S_SUPPORTED(1), .U_SUPPORTED(1), .FP_SUPPORTED(1)) dut (
    .clk(clk), .reset_n(reset_n), .StallW(StallW), .TrapM(TrapM),
    .NextPrivilegeModeM(NextPrivilegeModeM), .PrivilegeModeW(PrivilegeModeW),
    .mretM(mretM), .sretM(sretM), .WriteMSTATUSM(WriteMSTATUSM), .WriteSSTATUSM(WriteSSTATUSM),
    .CSRWriteValM(CSRWriteValM), .FRegWriteM(FRegWriteM), .WriteFRMM(WriteFRMM),
    .WriteFFLAGSM(WriteFFLAGSM), .ClearOvfM(ClearOvfM),
    .MSTATUS_REGW(MSTATUS_REGW), .SSTATUS_REGW(SSTATUS_REGW),
    .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_MPIE(STATUS_MPIE),
    .STATUS_SPIE(STATUS_SPIE), .STATUS_SPP(STATUS_SPP), .STATUS_MPP(STATUS_MPP),
    .STATUS_FS(STATUS_FS), .NestDepth(NestDepth), .NestOvf(NestOvf), .NestUnf(NestUnf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic idle_inputs();
    StallW = 0; TrapM = 0; mretM = 0; sretM = 0;
    NextPrivilegeModeM = 2'b00; PrivilegeModeW = 2'b00;
    WriteMSTATUSM = 0; WriteSSTATUSM = 0; CSRWriteValM = '0;
    FRegWriteM = 0; WriteFRMM = 0; WriteFFLAGSM = 0; ClearOvfM = 0;
  endtask

  // One clock with the currently driven inputs, then sample 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic mtrap(input logic [1:0] priv);
    TrapM = 1; NextPrivilegeModeM = 2'b11; PrivilegeModeW = priv;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    #1;
    chk("rst_mstatus", MSTATUS_REGW, 64'h0);
    chk("rst_depth", 64'(NestDepth), 64'd0);
    chk("rst_ovf_unf", {62'b0, NestOvf, NestUnf}, 64'd0);
    #11 reset_n = 1;

    CSRWriteValM = 64'h8; WriteMSTATUSM = 1; cyc();
    chk("wr_mie", MSTATUS_REGW, 64'h8);

    mtrap(2'b00); cyc();
    chk("trap1_depth", 64'(NestDepth), 64'd1);
    chk("trap1_mstatus", MSTATUS_REGW, 64'h80);
    mtrap(2'b11); cyc();
    chk("trap2_depth", 64'(NestDepth), 64'd2);
    chk("trap2_mstatus", MSTATUS_REGW, 64'h1800);
    mtrap(2'b11); ClearOvfM = 1; cyc();
    chk("trap3_depth", 64'(NestDepth), 64'd2);
    chk("trap3_ovf_beats_clear", 64'(NestOvf), 64'd1);
    chk("trap3_mstatus", MSTATUS_REGW, 64'h1800);

    mretM = 1; cyc();
    chk("mret1_depth", 64'(NestDepth), 64'd1);
    chk("mret1_mstatus", MSTATUS_REGW, 64'h1800);
    mretM = 1; cyc();
    chk("mret2_depth", 64'(NestDepth), 64'd0);
    chk("mret2_mstatus", MSTATUS_REGW, 64'h80);
    chk("mret2_unf", 64'(NestUnf), 64'd0);
    mretM = 1; cyc();
    chk("mret3_unf", 64'(NestUnf), 64'd1);
    chk("mret3_mstatus", MSTATUS_REGW, 64'h88);
    chk("mret3_depth", 64'(NestDepth), 64'd0);
    ClearOvfM = 1; cyc();
    chk("unf_pulse_end", 64'(NestUnf), 64'd0);
    chk("ovf_cleared", 64'(NestOvf), 64'd0);

    mtrap(2'b00); mretM = 1; cyc();
    chk("trap_mret_depth", 64'(NestDepth), 64'd1);
    chk("trap_mret_mstatus", MSTATUS_REGW, 64'h80);

    mtrap(2'b11); StallW = 1; cyc();
    chk("stall_depth", 64'(NestDepth), 64'd1);
    chk("stall_mstatus", MSTATUS_REGW, 64'h80);
    mtrap(2'b11); cyc();
    chk("unstall_depth", 64'(NestDepth), 64'd2);
    chk("unstall_mstatus", MSTATUS_REGW, 64'h1800);

    CSRWriteValM = 64'h1000; WriteMSTATUSM = 1; cyc();
    chk("mpp10_to_11", 64'(STATUS_MPP), 64'd3);
    chk("wr_depth_kept", 64'(NestDepth), 64'd2);
    CSRWriteValM = 64'h3800; WriteMSTATUSM = 1; cyc();
    chk("fs01", MSTATUS_REGW, 64'h3800);
    FRegWriteM = 1; cyc();
    chk("fs_dirty", MSTATUS_REGW, 64'h8000_0000_0000_7800);
    chk("fs_dirty_sstatus", SSTATUS_REGW, 64'h8000_0000_0000_6000);

    CSRWriteValM = 64'h2; WriteSSTATUSM = 1; cyc();
    chk("wr_sstatus_m", MSTATUS_REGW, 64'h1802);
    chk("wr_sstatus_s", SSTATUS_REGW, 64'h2);
    TrapM = 1; NextPrivilegeModeM = 2'b01; PrivilegeModeW = 2'b00; cyc();
    chk("strap_sstatus", SSTATUS_REGW, 64'h20);
    chk("strap_depth", 64'(NestDepth), 64'd2);
    sretM = 1; cyc();
    chk("sret_sstatus", SSTATUS_REGW, 64'h22);

    mretM = 1; cyc();
    chk("pop_depth", 64'(NestDepth), 64'd1);
    chk("pop_mstatus", MSTATUS_REGW, 64'hA2);

    mtrap(2'b11);
    #3 reset_n = 0;
    #1;
    chk("async_rst_mstatus", MSTATUS_REGW, 64'h0);
    chk("async_rst_depth", 64'(NestDepth), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("rst_held_mstatus", MSTATUS_REGW, 64'h0);
    chk("rst_held_flags", {61'b0, NestOvf, NestUnf, 1'b0} | 64'(NestDepth), 64'd0);
    reset_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
